// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  // Access sequencer states: grant in IDLE, strobe in ACCESS, sample memory in CAPTURE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // Port identifiers carried through the access.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Default byte capacity of the attached memory.
  localparam int MEM_BYTES_DEF = 1024;

  // True when a word access at byte address a would run past the last byte.
  function automatic logic addr_oor(input logic [31:0] a, input int mem_bytes);
    return a > 32'(mem_bytes - 2);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: grant selection between the fetch and data ports.
// With MEM_ARB_RR_EN defined, ties go to the port named by fav_d; otherwise
// the data port always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_elig,
  input  logic d_elig,
`ifdef MEM_ARB_RR_EN
  input  logic fav_d,
`endif
  output logic gnt_vld,
  output logic gnt_port
);

  // Pick the winning port among the eligible requesters.
  always_comb begin
    gnt_vld  = i_elig | d_elig;
    gnt_port = PORT_I;
`ifdef MEM_ARB_RR_EN
    if (i_elig && d_elig) gnt_port = fav_d ? PORT_D : PORT_I;
    else if (d_elig)      gnt_port = PORT_D;
`else
    if (d_elig)           gnt_port = PORT_D;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data two-port arbiter in front of a synchronous memory.
// One access every three cycles: grant (IDLE) -> strobe (ACCESS) -> sample
// memory word (CAPTURE) -> ack. Optional macro MEM_ARB_RR_EN selects
// round-robin tie breaking instead of fixed data-port priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic              inp_clk,
  input  logic              inp_rst,
  input  logic              inp_i_req,
  input  logic [ADDR_W-1:0] inp_i_addr,
  output logic              out_i_ack,
  output logic [DATA_W-1:0] out_i_rdata,
  output logic              out_i_err,
  input  logic              inp_d_req,
  input  logic              inp_d_we,
  input  logic [ADDR_W-1:0] inp_d_addr,
  input  logic [DATA_W-1:0] inp_d_wdata,
  output logic              out_d_ack,
  output logic [DATA_W-1:0] out_d_rdata,
  output logic              out_d_err,
  output logic [ADDR_W-1:0] out_mem_address,
  output logic [DATA_W-1:0] out_mem_dataWrite,
  output logic              out_mem_memRead,
  output logic              out_mem_memWrite,
  input  logic [DATA_W-1:0] inp_mem_read,
  output logic              out_busy
);

  state_t              state_q, state_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic                oor_q, oor_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic                i_err_q, i_err_d;
  logic                d_err_q, d_err_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
`ifdef MEM_ARB_RR_EN
  logic                rr_q, rr_d;   // 1 = data port favoured on the next tie
`endif

  logic                i_elig, d_elig;
  logic                gnt_vld, gnt_port;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_we;
  logic                sel_oor;
  logic [DATA_W-1:0]   cap_word;

  // A port competes only while idle and not in its own ack cycle, so a
  // request held across its ack is not granted a second time.
  assign i_elig = (state_q == ST_IDLE) & inp_i_req & ~i_ack_q;
  assign d_elig = (state_q == ST_IDLE) & inp_d_req & ~d_ack_q;

  mem_arb_pick u_pick (
    .i_elig   (i_elig),
    .d_elig   (d_elig),
`ifdef MEM_ARB_RR_EN
    .fav_d    (rr_q),
`endif
    .gnt_vld  (gnt_vld),
    .gnt_port (gnt_port)
  );

  // Request fields of the winning port, evaluated on the grant edge.
  assign sel_addr = (gnt_port == PORT_D) ? inp_d_addr : inp_i_addr;
  assign sel_we   = (gnt_port == PORT_D) & inp_d_we;
  assign sel_oor  = addr_oor(32'(sel_addr), MEM_BYTES);
  // Out-of-range reads return zero rather than whatever the memory holds.
  assign cap_word = oor_q ? '0 : inp_mem_read;

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    we_d      = we_q;
    oor_d     = oor_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    d_err_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    rr_d      = rr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          state_d = ST_ACCESS;
          port_d  = gnt_port;
          we_d    = sel_we;
          oor_d   = sel_oor;
          addr_d  = sel_addr;
          if (gnt_port == PORT_D) wdata_d = inp_d_wdata;
          rd_d    = ~sel_oor & ~sel_we;
          wr_d    = ~sel_oor &  sel_we;
`ifdef MEM_ARB_RR_EN
          rr_d    = (gnt_port == PORT_I);
`endif
        end
      end
      ST_ACCESS: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
        if (port_q == PORT_D) begin
          d_ack_d = 1'b1;
          d_err_d = oor_q;
          if (!we_q) d_rdata_d = cap_word;
        end else begin
          i_ack_d   = 1'b1;
          i_err_d   = oor_q;
          i_rdata_d = cap_word;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears everything and abandons any access.
  always_ff @(posedge inp_clk or posedge inp_rst) begin
    if (inp_rst) begin
      state_q   <= ST_IDLE;
      port_q    <= PORT_D;
      we_q      <= 1'b0;
      oor_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      rr_q      <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      we_q      <= we_d;
      oor_q     <= oor_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_err_q   <= i_err_d;
      d_err_q   <= d_err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign out_i_ack         = i_ack_q;
  assign out_i_rdata       = i_rdata_q;
  assign out_i_err         = i_err_q;
  assign out_d_ack         = d_ack_q;
  assign out_d_rdata       = d_rdata_q;
  assign out_d_err         = d_err_q;
  assign out_mem_address   = addr_q;
  assign out_mem_dataWrite = wdata_q;
  assign out_mem_memRead   = rd_q;
  assign out_mem_memWrite  = wr_q;
  assign out_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed bench for mem_arbiter with a
// transaction-level reference model and a byte-array memory device.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int MB = 1024;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [15:0] d_addr = '0, d_wdata = '0;
  logic        i_ack, i_err, d_ack, d_err, m_rd, m_wr, busy;
  logic [15:0] i_rdata, d_rdata, m_addr, m_wdata;
  bit   [15:0] m_rword;

  mem_arbiter dut (
    .inp_clk(clk), .inp_rst(rst),
    .inp_i_req(i_req), .inp_i_addr(i_addr),
    .out_i_ack(i_ack), .out_i_rdata(i_rdata), .out_i_err(i_err),
    .inp_d_req(d_req), .inp_d_we(d_we), .inp_d_addr(d_addr), .inp_d_wdata(d_wdata),
    .out_d_ack(d_ack), .out_d_rdata(d_rdata), .out_d_err(d_err),
    .out_mem_address(m_addr), .out_mem_dataWrite(m_wdata),
    .out_mem_memRead(m_rd), .out_mem_memWrite(m_wr),
    .inp_mem_read(m_rword), .out_busy(busy)
  );

  always #5 clk = ~clk;

  // Attached synchronous memory: byte array, little-endian word at a, a+1.
  bit [7:0] dev [MB];
  always @(posedge clk) begin
    if (m_wr && int'(m_addr) <= MB-2) begin
      dev[int'(m_addr)]   <= m_wdata[7:0];
      dev[int'(m_addr)+1] <= m_wdata[15:8];
    end
    if (m_rd && int'(m_addr) <= MB-2)
      m_rword <= {dev[int'(m_addr)+1], dev[int'(m_addr)]};
  end

  // Reference model: last granted transaction and the cycle it was granted.
  int          cyc = 0;
  int          g_cyc = -100;
  bit          g_port, g_we, g_oor;
  logic [15:0] g_addr, g_wdata, g_rdata;
  bit          fav_d = 1'b1;
  logic [15:0] e_i_rdata = '0, e_d_rdata = '0;
  bit   [7:0]  rmem [MB];
  int          n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    g_cyc = -100; fav_d = 1'b1; e_i_rdata = '0; e_d_rdata = '0;
  endtask

  // Decide the grant (if any) for the current cycle from the current inputs.
  task automatic model_grant();
    bit ie, de, p, ack_now;
    int a;
    ack_now = (cyc == g_cyc + 3);
    if (rst || cyc < g_cyc + 3) return;
    ie = i_req && !(ack_now && g_port == 1'b0);
    de = d_req && !(ack_now && g_port == 1'b1);
    if (!(ie || de)) return;
    if (ie && de) p = RR ? fav_d : 1'b1;
    else          p = de;
    g_cyc = cyc; g_port = p; g_we = p & d_we;
    g_addr = p ? d_addr : i_addr; g_wdata = d_wdata;
    a = int'(g_addr);
    g_oor = (a > MB - 2);
    g_rdata = '0;
    if (!g_oor) begin
      if (g_we) begin rmem[a] = g_wdata[7:0]; rmem[a+1] = g_wdata[15:8]; end
      else g_rdata = {rmem[a+1], rmem[a]};
    end
    fav_d = !p;
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic model_check();
    bit acc, ackc;
    acc  = (cyc == g_cyc + 1);
    ackc = (cyc == g_cyc + 3);
    if (ackc && !g_we) begin
      if (g_port) e_d_rdata = g_oor ? 16'h0 : g_rdata;
      else        e_i_rdata = g_oor ? 16'h0 : g_rdata;
    end
    chk("busy",    busy, (acc || cyc == g_cyc + 2));
    chk("memRead", m_rd, acc && !g_oor && !g_we);
    chk("memWrite",m_wr, acc && !g_oor && g_we);
    chk("i_ack",   i_ack, ackc && !g_port);
    chk("d_ack",   d_ack, ackc && g_port);
    chk("i_err",   i_err, ackc && !g_port && g_oor);
    chk("d_err",   d_err, ackc && g_port && g_oor);
    chk("i_rdata", i_rdata, e_i_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
    if (acc && !g_oor) chk("mem_addr", m_addr, g_addr);
    if (acc && !g_oor && g_we) chk("mem_wdata", m_wdata, g_wdata);
  endtask

  task automatic tick();
    model_grant();
    @(posedge clk); #1;
    cyc++;
    model_check();
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 0; d_req = 0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Issue one request, hold it until ack, return latency/result and strobe count.
  task automatic do_req(input bit p, input bit we, input logic [15:0] a, input logic [15:0] wd,
                        output int lat, output logic [15:0] rd, output bit er, output int nstb);
    bit done = 0;
    lat = 0; nstb = 0; rd = '0; er = 0;
    if (p) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
    else   begin i_req = 1; i_addr = a; end
    while (!done && lat < 20) begin
      tick(); lat++;
      nstb += int'(m_rd) + int'(m_wr);
      if (p ? d_ack : i_ack) begin done = 1; rd = p ? d_rdata : i_rdata; er = p ? d_err : i_err; end
    end
    if (!done) chk("req_timeout", 0, 1);
    i_req = 0; d_req = 0;
    tick();
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return 16'($urandom_range(0, 31));
      6, 7:             return 16'($urandom_range(1018, 1023));
      8:                return 16'($urandom_range(0, 65535));
      default:          return 16'($urandom_range(0, 1022));
    endcase
  endfunction

  int lat, nstb, base, na, dk, ik;
  logic [15:0] rd;
  bit er;
  int   ack_cyc [4];
  bit   ack_prt [4];

  initial begin
    model_reset();
    tick();
    // Reset state literals.
    chk("rst_busy", busy, 0);   chk("rst_rd", m_rd, 0);      chk("rst_wr", m_wr, 0);
    chk("rst_addr", m_addr, 0); chk("rst_iack", i_ack, 0);   chk("rst_drdata", d_rdata, 0);
    rst = 1'b0;
    tick();

    // Write then read back through the other port.
    do_req(1, 1, 16'h0010, 16'hBEEF, lat, rd, er, nstb);
    chk("wr_lat", lat, 3); chk("wr_strobes", nstb, 1); chk("wr_err", er, 0);
    do_req(0, 0, 16'h0010, 16'h0, lat, rd, er, nstb);
    chk("rd_lat", lat, 3); chk("rd_data", rd, 16'hBEEF); chk("rd_strobes", nstb, 1);

    // Odd address word.
    do_req(1, 1, 16'h0021, 16'hA55A, lat, rd, er, nstb);
    do_req(0, 0, 16'h0021, 16'h0, lat, rd, er, nstb);
    chk("odd_data", rd, 16'hA55A);

    // Range boundary.
    do_req(1, 1, 16'h03FE, 16'h1234, lat, rd, er, nstb);
    do_req(1, 0, 16'h03FF, 16'h0, lat, rd, er, nstb);
    chk("oor_lat", lat, 3); chk("oor_err", er, 1); chk("oor_data", rd, 16'h0); chk("oor_strobes", nstb, 0);
    do_req(1, 0, 16'h03FE, 16'h0, lat, rd, er, nstb);
    chk("edge_err", er, 0); chk("edge_data", rd, 16'h1234); chk("edge_strobes", nstb, 1);

    // Simultaneous requests, each dropped after its ack.
    do_reset();
    i_req = 1; i_addr = 16'h0010; d_req = 1; d_we = 0; d_addr = 16'h0021;
    base = cyc; dk = -1; ik = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (d_ack) begin dk = cyc - base; d_req = 0; end
      if (i_ack) begin ik = cyc - base; i_req = 0; end
    end
    chk("tie_d_cyc", dk, 3); chk("tie_i_cyc", ik, 6);

    // Both held continuously: grants alternate.
    do_reset();
    i_req = 1; i_addr = 16'h0010; d_req = 1; d_we = 0; d_addr = 16'h0021;
    base = cyc; na = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if ((d_ack || i_ack) && na < 4) begin ack_cyc[na] = cyc - base; ack_prt[na] = d_ack; na++; end
    end
    i_req = 0; d_req = 0;
    for (int k = 0; k < 4; k++) tick();
    chk("alt_count", na, 4);
    for (int k = 0; k < 4; k++) begin
      chk("alt_cyc", ack_cyc[k], 3 * (k + 1));
      chk("alt_port", ack_prt[k], (k % 2 == 0));
    end

    // Fetch request held across its ack: one ack per grant.
    i_req = 1; i_addr = 16'h0010; base = cyc; na = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (i_ack && na < 4) begin ack_cyc[na] = cyc - base; na++; end
    end
    i_req = 0;
    for (int k = 0; k < 4; k++) tick();
    chk("hold_count", na, 2); chk("hold_ack0", ack_cyc[0], 3); chk("hold_ack1", ack_cyc[1], 7);

    // Reset during ACCESS.
    i_req = 1; i_addr = 16'h0010;
    tick();
    chk("pre_rst_rd", m_rd, 1); chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1; i_req = 0;
    #1;
    chk("rst_async_rd", m_rd, 0); chk("rst_async_busy", busy, 0);
    model_reset();
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    do_req(0, 0, 16'h0010, 16'h0, lat, rd, er, nstb);
    chk("post_rst_lat", lat, 3); chk("post_rst_data", rd, 16'hBEEF);

    // Randomized traffic with hold-until-ack agents on both ports.
    for (int k = 0; k < 4000; k++) begin
      if (i_req && i_ack) i_req = 0;
      if (d_req && d_ack) d_req = 0;
      if (!i_req && $urandom_range(0, 2) == 0) begin i_req = 1; i_addr = rand_addr(); end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = $urandom_range(0, 1) == 1; d_addr = rand_addr(); d_wdata = 16'($urandom);
      end
      tick();
    end
    i_req = 0; d_req = 0;
    for (int k = 0; k < 6; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width of both ports and the memory side.
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have parameter MEM_BYTES, default 1024, byte capacity of the attached memory.
REQ-004 SHALL have port inp_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port inp_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports inp_i_req (1), inp_i_addr (ADDR_W) as inputs: fetch-port read request and byte address.
REQ-007 SHALL have ports out_i_ack (1), out_i_rdata (DATA_W), out_i_err (1) as outputs: fetch-port completion pulse, read word and range error.
REQ-008 SHALL have ports inp_d_req (1), inp_d_we (1), inp_d_addr (ADDR_W), inp_d_wdata (DATA_W) as inputs: data-port request, 1 = write, byte address, write word.
REQ-009 SHALL have ports out_d_ack (1), out_d_rdata (DATA_W), out_d_err (1) as outputs: data-port completion pulse, read word and range error.
REQ-010 SHALL have outputs out_mem_address (ADDR_W), out_mem_dataWrite (DATA_W), out_mem_memRead (1), out_mem_memWrite (1) driving the synchronous memory, plus input inp_mem_read (DATA_W) carrying its registered read word.
REQ-011 SHALL have output out_busy  1  high whenever the state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, ACCESS and CAPTURE; IDLE->ACCESS on grant, ACCESS->CAPTURE always, CAPTURE->IDLE always.
REQ-013 SHALL, in IDLE, treat a port as requesting only when its req is high and its own ack is low in that cycle (hold-until-ack handshake; no double grant).
REQ-014 SHALL, on the grant edge, latch port id, address, we and wdata; requester inputs are ignored until that port's ack.
REQ-015 SHALL assert exactly one memory strobe (memRead, or memWrite for a data write) for exactly the ACCESS cycle, never both, with address/dataWrite registered and stable for that cycle.
REQ-016 SHALL, on the CAPTURE edge, load the granted port's rdata from inp_mem_read (reads only) and pulse its ack high for exactly one cycle.
REQ-017 SHALL give latency 3: req sampled in IDLE at cycle 0, strobe in cycle 1, ack and rdata valid in cycle 3; peak throughput one access per 3 cycles.
REQ-018 SHALL hold out_x_rdata unchanged between reads; a data write SHALL leave out_d_rdata unchanged.
REQ-019 SHALL treat address > MEM_BYTES-2 as out of range: no strobe in ACCESS, same latency, ack with err=1 and rdata=0; err SHALL be 0 otherwise and valid only while ack is high.
REQ-020 SHALL accept odd addresses in range (word occupies addr and addr+1).
REQ-021 SHALL, on simultaneous eligible requests without ARB_RR_EN, always grant the data port.

Reset
REQ-022 SHALL, while inp_rst is high, force state IDLE and all outputs to 0 immediately.
REQ-023 SHALL abandon any in-flight access on reset with no ack; completion of a write whose ACCESS cycle is cut by reset is not guaranteed.
REQ-024 SHALL reset the round-robin pointer (when present) to favour the data port.

Configuration
REQ-025 SHALL, with macro MEM_ARB_RR_EN defined, arbitrate simultaneous requests round-robin: the pointer favours the port not granted last and updates on every grant.
REQ-026 SHALL, without MEM_ARB_RR_EN, use fixed data-port priority and contain no pointer register.

Structure
REQ-027 SHALL place the state encoding, port-id constants (PORT_I=0, PORT_D=1) and default MEM_BYTES in shared package mem_arb_pkg.
REQ-028 SHALL isolate grant selection (priority/round-robin) in sub-module mem_arb_pick.

Verification
REQ-029 SHALL cover: d write addr 0x0010 data 0xBEEF, then i read 0x0010 -> i ack at cycle 3 with rdata 0xBEEF, memWrite high exactly one cycle.
REQ-030 SHALL cover: i and d read requests in the same cycle, no macro -> d acked at cycle 3, i at cycle 6; with MEM_ARB_RR_EN and both held continuously -> grants alternate D,I,D,I.
REQ-031 SHALL cover: d read addr 0x03FF (MEM_BYTES 1024) -> no strobe, ack at cycle 3 with err=1, rdata=0x0000; addr 0x03FE -> err=0.
REQ-032 SHALL cover: i req held high across its ack -> exactly one ack per grant, no back-to-back regrant of the same request.
REQ-033 SHALL cover: inp_rst asserted during ACCESS -> strobes and out_busy drop to 0 asynchronously, no ack, next request completes normally.
